// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, event payload and decoder state type for the
// PS/2 Set-2 key event queue.
package ps2_pkg;

    // Set-2 prefix and control bytes
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_BAT        = 8'hAA;
    localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

    // Keyboard replies / error codes that never form part of a key sequence
    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_ERR_LO  = 8'h00;
    localparam logic [7:0] PS2_ERR_HI  = 8'hFF;

    // Bytes that follow E1 before the Pause event is complete
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
    } key_event_t;

    typedef enum logic [2:0] {
        DEC_IDLE    = 3'd0,
        DEC_EXT     = 3'd1,
        DEC_BRK     = 3'd2,
        DEC_EXT_BRK = 3'd3,
        DEC_PAUSE   = 3'd4
    } ps2_dec_state_t;

    // Held-map index of an event: {ext, code}
    function automatic logic [8:0] held_idx(input key_event_t ev);
        return {ev.ext, ev.code};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: key_event_t FIFO with a registered first-word-fallthrough
// head.
//   clk, rst      clock, asynchronous active-high reset
//   i_push        push request (accepted when not full, or when popping)
//   i_push_data   event to push
//   i_pop         pop request (ignored when empty)
//   o_head        head event (registered)
//   o_valid       head valid / FIFO non-empty (registered)
//   o_count       occupancy (registered)
//   o_full        occupancy == DEPTH (registered)
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  key_event_t               i_push_data,
    input  logic                     i_pop,
    output key_event_t               o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    key_event_t       r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_valid;
    key_event_t       r_head;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [AW-1:0]    w_rd_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_remain;
    key_event_t       w_head_nxt;
    logic             w_valid_nxt;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_pop_ok    = i_pop && r_valid;
    assign w_push_ok   = i_push && (!r_full || w_pop_ok);
    assign w_rd_nxt    = r_rd + AW'(w_pop_ok);
    assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    assign w_remain    = r_count - CW'(w_pop_ok);

    // Next head: the surviving oldest entry, or the pushed event if nothing survives
    always_comb begin
        w_head_nxt  = r_head;
        w_valid_nxt = 1'b0;
        if (w_remain != '0) begin
            w_head_nxt  = r_mem[w_rd_nxt];
            w_valid_nxt = 1'b1;
        end else if (w_push_ok) begin
            w_head_nxt  = i_push_data;
            w_valid_nxt = 1'b1;
        end
    end

    // Storage array needs no reset; occupancy tracking guards every read
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_valid <= 1'b0;
            r_head  <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push_ok);
            r_rd    <= w_rd_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_valid <= w_valid_nxt;
            r_head  <= w_head_nxt;
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_full  = r_full;

endmodule

// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue: decodes a PS/2 Set-2 byte stream (E0 extended, E0 F0
// extended break, E1 Pause) into key events, filters typematic repeats and
// queues the events for a valid/ready consumer.
//   clk, rst            clock, asynchronous active-high reset
//   rx_byte, rx_valid   received scan byte and its one-cycle strobe
//   ev_code/ext/make    head event fields
//   ev_valid, ev_ready  head handshake
//   ev_count            queue occupancy
//   overflow            sticky dropped-event flag, cleared by overflow_clr
module ps2_key_event_queue
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned SUPPRESS_REPEAT = 1,
    parameter int unsigned PREFIX_TIMEOUT  = 200_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_make,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int unsigned TW = $clog2(PREFIX_TIMEOUT + 1);

    ps2_dec_state_t  r_state;
    ps2_dec_state_t  w_state_nxt;
    logic [2:0]      r_skip;
    logic [2:0]      w_skip_nxt;
    logic [TW-1:0]   r_tmo;
    logic            w_tmo_hit;
    logic [511:0]    r_held;
    logic            r_overflow;

    logic            w_emit;
    logic            w_is_pause;
    logic            w_clr_held;
    key_event_t      w_ev;
    logic [8:0]      w_idx;
    logic            w_suppress;
    logic            w_push;
    logic            w_drop;

    key_event_t      w_head;
    logic            w_valid;
    logic            w_full;

    // Partial sequence has waited the full budget without a new byte
    assign w_tmo_hit = (r_state != DEC_IDLE) && !rx_valid &&
                       (r_tmo == TW'(PREFIX_TIMEOUT - 1));

    // Decoder state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DEC_IDLE;
            r_skip  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    // Decoder next state and event generation
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_emit      = 1'b0;
        w_is_pause  = 1'b0;
        w_clr_held  = 1'b0;
        w_ev        = '0;
        if (rx_valid) begin
            case (r_state)
                DEC_IDLE: begin
                    case (rx_byte)
                        PS2_EXT:   w_state_nxt = DEC_EXT;
                        PS2_BRK:   w_state_nxt = DEC_BRK;
                        PS2_PAUSE: begin
                            w_state_nxt = DEC_PAUSE;
                            w_skip_nxt  = PAUSE_SKIP;
                        end
                        PS2_BAT:   w_clr_held = 1'b1;
                        PS2_ACK, PS2_ECHO, PS2_RESEND,
                        PS2_ERR_LO, PS2_ERR_HI: ;
                        default: begin
                            w_emit = 1'b1;
                            w_ev   = '{ext: 1'b0, make: 1'b1, code: rx_byte};
                        end
                    endcase
                end
                DEC_EXT: begin
                    case (rx_byte)
                        PS2_BRK:            w_state_nxt = DEC_EXT_BRK;
                        PS2_EXT, PS2_PAUSE: w_state_nxt = DEC_EXT;
                        PS2_FAKE_SHIFT:     w_state_nxt = DEC_IDLE;
                        default: begin
                            w_state_nxt = DEC_IDLE;
                            w_emit      = 1'b1;
                            w_ev        = '{ext: 1'b1, make: 1'b1, code: rx_byte};
                        end
                    endcase
                end
                DEC_BRK: begin
                    w_state_nxt = DEC_IDLE;
                    w_emit      = 1'b1;
                    w_ev        = '{ext: 1'b0, make: 1'b0, code: rx_byte};
                end
                DEC_EXT_BRK: begin
                    w_state_nxt = DEC_IDLE;
                    if (rx_byte != PS2_FAKE_SHIFT) begin
                        w_emit = 1'b1;
                        w_ev   = '{ext: 1'b1, make: 1'b0, code: rx_byte};
                    end
                end
                DEC_PAUSE: begin
                    // Swallow the rest of E1 14 77 E1 F0 14 F0 77, then report once
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_state_nxt = DEC_IDLE;
                        w_emit      = 1'b1;
                        w_is_pause  = 1'b1;
                        w_ev        = '{ext: 1'b1, make: 1'b1, code: PS2_PAUSE};
                    end
                end
                default: w_state_nxt = DEC_IDLE;
            endcase
        end else if (w_tmo_hit) begin
            w_state_nxt = DEC_IDLE;
        end
    end

    // Inter-byte timeout counter, only meaningful mid-sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (r_state == DEC_IDLE || rx_valid || w_tmo_hit) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // Held-key map; Pause has no release so it never enters the map
    assign w_idx = held_idx(w_ev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= '0;
        end else if (w_clr_held) begin
            r_held <= '0;
        end else if (w_emit && !w_is_pause) begin
            r_held[w_idx] <= w_ev.make;
        end
    end

    assign w_suppress = (SUPPRESS_REPEAT != 0) && w_ev.make && !w_is_pause &&
                        r_held[w_idx];
    assign w_push     = w_emit && !w_suppress;
    assign w_drop     = w_push && w_full && !(ev_ready && w_valid);

    // Sticky overflow; a new drop outranks a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    ps2_event_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_ev),
        .i_pop       (ev_ready),
        .o_head      (w_head),
        .o_valid     (w_valid),
        .o_count     (ev_count),
        .o_full      (w_full)
    );

    assign ev_code  = w_head.code;
    assign ev_ext   = w_head.ext;
    assign ev_make  = w_head.make;
    assign ev_valid = w_valid;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue: decode, repeat filtering, Pause,
// FIFO overflow, prefix timeout and asynchronous reset.
module tb_ps2_key_event_queue;

    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ev_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic       ready0 = 1'b0;

    logic [7:0] ev_code;
    logic       ev_ext, ev_make, ev_valid, overflow;
    logic [3:0] ev_count;

    logic [7:0] ev_code0;
    logic       ev_ext0, ev_make0, ev_valid0, overflow0;
    logic [3:0] ev_count0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_key_event_queue #(
        .FIFO_DEPTH(8), .SUPPRESS_REPEAT(1), .PREFIX_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_make(ev_make),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_count(ev_count),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    ps2_key_event_queue #(
        .FIFO_DEPTH(8), .SUPPRESS_REPEAT(0), .PREFIX_TIMEOUT(TMO)
    ) dut0 (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .ev_code(ev_code0), .ev_ext(ev_ext0), .ev_make(ev_make0),
        .ev_valid(ev_valid0), .ev_ready(ready0), .ev_count(ev_count0),
        .overflow(overflow0), .overflow_clr(overflow_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte strobe; returns 1 time unit after the capturing edge
    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 rx_byte = b; rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Check the head against an expected event, then pop it
    task automatic pop_exp(input string tag, input logic [7:0] code,
                           input logic ext, input logic make);
        chk({tag, ".valid"}, 32'(ev_valid), 32'd1);
        chk({tag, ".code"},  32'(ev_code),  32'(code));
        chk({tag, ".ext"},   32'(ev_ext),   32'(ext));
        chk({tag, ".make"},  32'(ev_make),  32'(make));
        ev_ready = 1'b1;
        @(posedge clk);
        #1 ev_ready = 1'b0;
    endtask

    task automatic rst_pulse();
        #1 rst = 1'b1;
        #1 chk("async_rst_valid", 32'(ev_valid), 32'd0);
        #1 rst = 1'b0;
    endtask

    logic [7:0] ovf_in  [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    logic [7:0] ovf_out [8] = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h4B};

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_code",  32'(ev_code),  32'h00);
        chk("rst_ext",   32'(ev_ext),   32'd0);
        chk("rst_make",  32'(ev_make),  32'd0);
        chk("rst_count", 32'(ev_count), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);

        // Plain make with latency, then break
        @(posedge clk);
        #1 rx_byte = 8'h1C; rx_valid = 1'b1;
        chk("lat_before", 32'(ev_valid), 32'd0);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        chk("lat_after", 32'(ev_valid), 32'd1);
        chk("lat_count", 32'(ev_count), 32'd1);
        send(8'hF0); send(8'h1C);
        chk("mb_count", 32'(ev_count), 32'd2);
        pop_exp("make_1c", 8'h1C, 1'b0, 1'b1);
        pop_exp("brk_1c",  8'h1C, 1'b0, 1'b0);
        chk("mb_empty", 32'(ev_valid), 32'd0);

        // Extended make/break and fake shift
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h12);
        chk("ext_count", 32'(ev_count), 32'd2);
        pop_exp("make_e75", 8'h75, 1'b1, 1'b1);
        pop_exp("brk_e75",  8'h75, 1'b1, 1'b0);
        chk("fake_shift_empty", 32'(ev_count), 32'd0);

        // Repeat filtering on dut, pass-through on dut0
        rst_pulse();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        chk("rep_count",   32'(ev_count),  32'd2);
        chk("norep_count", 32'(ev_count0), 32'd4);
        chk("norep_valid", 32'(ev_valid0), 32'd1);
        chk("norep_head",  32'({ev_ext0, ev_make0, ev_code0}), 32'h11C);
        chk("norep_ovf",   32'(overflow0), 32'd0);
        pop_exp("rep_make", 8'h1C, 1'b0, 1'b1);
        pop_exp("rep_brk",  8'h1C, 1'b0, 1'b0);

        // Pause sequence, followed by a normal key
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("pause_count", 32'(ev_count), 32'd1);
        send(8'h1C);
        pop_exp("pause", 8'hE1, 1'b1, 1'b1);
        pop_exp("post_pause", 8'h1C, 1'b0, 1'b1);
        send(8'hF0); send(8'h1C);
        pop_exp("post_pause_brk", 8'h1C, 1'b0, 1'b0);

        // Overflow: nine back-to-back makes into an 8-deep FIFO
        @(posedge clk);
        for (int i = 0; i < 9; i++) begin
            #1 rx_byte = ovf_in[i]; rx_valid = 1'b1;
            if (i == 8) begin
                chk("full_count", 32'(ev_count), 32'd8);
                chk("full_no_ovf", 32'(overflow), 32'd0);
            end
            @(posedge clk);
        end
        #1 rx_valid = 1'b0;
        chk("ovf_count", 32'(ev_count), 32'd8);
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_head",  32'(ev_code),  32'h15);
        overflow_clr = 1'b1;
        @(posedge clk);
        #1 overflow_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        // Push and pop together while full
        rx_byte = 8'h4B; rx_valid = 1'b1; ev_ready = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0; ev_ready = 1'b0;
        chk("pp_count", 32'(ev_count), 32'd8);
        chk("pp_ovf",   32'(overflow), 32'd0);
        // Drop and clear in the same cycle: set wins
        rx_byte = 8'h4D; rx_valid = 1'b1; overflow_clr = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0; overflow_clr = 1'b0;
        chk("setwin_ovf",   32'(overflow), 32'd1);
        chk("setwin_count", 32'(ev_count), 32'd8);
        for (int i = 0; i < 8; i++) pop_exp($sformatf("drain%0d", i), ovf_out[i], 1'b0, 1'b1);
        chk("drain_count", 32'(ev_count), 32'd0);
        overflow_clr = 1'b1;
        @(posedge clk);
        #1 overflow_clr = 1'b0;
        chk("ovf_clr2", 32'(overflow), 32'd0);

        // Prefix timeout: one cycle short keeps the prefix, exact budget drops it
        send(8'hE0);
        repeat (TMO - 2) @(posedge clk);
        send(8'h75);
        pop_exp("tmo_short", 8'h75, 1'b1, 1'b1);
        send(8'hE0);
        repeat (TMO - 1) @(posedge clk);
        send(8'h1C);
        chk("tmo_count", 32'(ev_count), 32'd1);
        pop_exp("tmo_hit", 8'h1C, 1'b0, 1'b1);

        // Reset mid-sequence and mid-FIFO
        send(8'h5A); send(8'hF0);
        chk("pre_rst_count", 32'(ev_count), 32'd1);
        rst_pulse();
        chk("post_rst_count", 32'(ev_count), 32'd0);
        send(8'h1C);
        pop_exp("post_rst_make", 8'h1C, 1'b0, 1'b1);

        // Held repeat suppressed, dropped reply byte, BAT clears held map
        send(8'h1C); send(8'hFA);
        chk("held_drop_count", 32'(ev_count), 32'd0);
        send(8'hAA); send(8'h1C);
        pop_exp("bat_make", 8'h1C, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
